// File: rtl/program_counter.sv
// program_counter
//   Instruction-address register for the fetch stage of a 4-lane SIMD array
//   processor. Each rising edge it resets, loads a jump target, advances, or
//   holds. In vector mode it advances every cycle. In scalar (lane-serial)
//   mode it advances only when the lane offset equals LAST_LANE, so a single
//   instruction occupies all four lane slots.
//
// Ports
//   clk          in   system clock, rising-edge
//   reset        in   synchronous, active-high reset (wins over everything)
//   vector       in   1 = advance every cycle, 0 = advance on last lane only
//   offset       in   current lane index (ignored when vector = 1)
//   jump_enable  in   1 = load jump_address on this edge (any mode/offset)
//   jump_address in   absolute jump target
//   address      out  current program counter, straight from the register
module program_counter #(
    parameter int unsigned          ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0,
    parameter logic [1:0]           LAST_LANE  = 2'b11
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  vector,
    input  logic [1:0]            offset,
    input  logic                  jump_enable,
    input  logic [ADDR_WIDTH-1:0] jump_address,
    output logic [ADDR_WIDTH-1:0] address
);

    logic [ADDR_WIDTH-1:0] address_q;
    logic [ADDR_WIDTH-1:0] address_d;
    logic                  advance;

    // Scalar mode steps only once the final lane of the instruction issues.
    assign advance = vector || (offset == LAST_LANE);

    // Reset is folded into the registered block; jump beats stepping here.
    always_comb begin
        address_d = address_q;
        if (jump_enable) begin
            address_d = jump_address;
        end else if (advance) begin
            // Modulo 2^ADDR_WIDTH wrap, no carry flag.
            address_d = address_q + ADDR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            address_q <= RESET_ADDR;
        end else begin
            address_q <= address_d;
        end
    end

    assign address = address_q;

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter. A driver applies directed vectors
// on the falling edge and pushes the hand-computed address expected after the
// next rising edge; a monitor samples shortly after each rising edge and
// compares against the queue head.
module tb_program_counter;

    logic       clk;
    logic       reset;
    logic       vector;
    logic [1:0] offset;
    logic       jump_enable;
    logic [7:0] jump_address;
    logic [7:0] address;

    int unsigned n_cmp;
    int unsigned n_bad;
    logic [7:0]  exp_q[$];
    string       name_q[$];

    program_counter #(
        .ADDR_WIDTH(8),
        .RESET_ADDR(8'd0),
        .LAST_LANE (2'b11)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .vector      (vector),
        .offset      (offset),
        .jump_enable (jump_enable),
        .jump_address(jump_address),
        .address     (address)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one registered result per rising edge while expectations exist.
    initial begin
        logic [7:0] exp_v;
        string      nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                exp_v = exp_q.pop_front();
                nm    = name_q.pop_front();
                n_cmp++;
                if (address !== exp_v) begin
                    n_bad++;
                    $display("FAIL %s: address got %0d expected %0d", nm, address, exp_v);
                end
            end
        end
    end

    task automatic step(input logic rst, input logic vec, input logic [1:0] off,
                        input logic je, input logic [7:0] ja, input logic [7:0] exp_v,
                        input string nm);
        @(negedge clk);
        reset        = rst;
        vector       = vec;
        offset       = off;
        jump_enable  = je;
        jump_address = ja;
        exp_q.push_back(exp_v);
        name_q.push_back(nm);
    endtask

    initial begin
        n_cmp        = 0;
        n_bad        = 0;
        reset        = 1'b1;
        vector       = 1'b0;
        offset       = 2'd0;
        jump_enable  = 1'b0;
        jump_address = 8'd0;

        //    rst   vec   off  je    ja      exp
        step(1'b1, 1'b0, 2'd0, 1'b0, 8'd0,   8'd0,   "reset");
        step(1'b0, 1'b1, 2'd0, 1'b0, 8'd0,   8'd1,   "vec_step1");
        step(1'b0, 1'b1, 2'd2, 1'b0, 8'd0,   8'd2,   "vec_step2");
        step(1'b0, 1'b1, 2'd1, 1'b0, 8'd0,   8'd3,   "vec_step3");
        step(1'b0, 1'b1, 2'd0, 1'b1, 8'd20,  8'd20,  "jump20");
        step(1'b0, 1'b1, 2'd0, 1'b0, 8'd0,   8'd21,  "after_jump");
        step(1'b0, 1'b0, 2'd0, 1'b0, 8'd0,   8'd21,  "scalar_off0");
        step(1'b0, 1'b0, 2'd1, 1'b0, 8'd0,   8'd21,  "scalar_off1");
        step(1'b0, 1'b0, 2'd2, 1'b0, 8'd0,   8'd21,  "scalar_off2");
        step(1'b0, 1'b0, 2'd3, 1'b0, 8'd0,   8'd22,  "scalar_off3");
        step(1'b0, 1'b0, 2'd0, 1'b0, 8'd0,   8'd22,  "scalar_off0b");
        step(1'b0, 1'b0, 2'd0, 1'b1, 8'd255, 8'd255, "jump255");
        step(1'b0, 1'b1, 2'd0, 1'b0, 8'd0,   8'd0,   "wrap");
        step(1'b0, 1'b1, 2'd0, 1'b0, 8'd0,   8'd1,   "post_wrap");
        step(1'b1, 1'b1, 2'd3, 1'b1, 8'd100, 8'd0,   "reset_over_jump");
        step(1'b0, 1'b1, 2'd0, 1'b0, 8'd0,   8'd1,   "after_reset");
        step(1'b0, 1'b0, 2'd1, 1'b1, 8'd50,  8'd50,  "jump_midlane");
        step(1'b0, 1'b0, 2'd1, 1'b0, 8'd0,   8'd50,  "hold_midlane");
        step(1'b0, 1'b1, 2'd0, 1'b1, 8'd50,  8'd50,  "jump_to_self");
        step(1'b0, 1'b1, 2'd0, 1'b0, 8'd0,   8'd51,  "resume_after_self");
        step(1'b0, 1'b0, 2'd3, 1'b0, 8'd0,   8'd52,  "scalar_last_lane");
        step(1'b0, 1'b0, 2'd3, 1'b0, 8'd0,   8'd53,  "scalar_last_lane2");
        step(1'b1, 1'b0, 2'd3, 1'b0, 8'd0,   8'd0,   "reset_scalar");
        step(1'b0, 1'b0, 2'd3, 1'b0, 8'd0,   8'd1,   "scalar_after_reset");
        step(1'b0, 1'b1, 2'd1, 1'b0, 8'd0,   8'd2,   "mode_switch_vec");
        step(1'b0, 1'b0, 2'd2, 1'b0, 8'd0,   8'd2,   "mode_switch_scalar");

        @(negedge clk);
        jump_enable = 1'b0;
        vector      = 1'b0;
        offset      = 2'd0;

        // Drain, bounded.
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: pending %0d expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: timeout reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
